alu_share_arbiter: RTL



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 48 ++++
 rtl/alu_share_arbiter_rr_arbiter.sv | 46 ++++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and operand widths.
package alu_pkg;

    localparam int unsigned ALU_OP_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_OR     = 4'd2,
        ALU_AND    = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_COPY_B = 4'd10,
        ALU_ADDW   = 4'd11,
        ALU_SUBW   = 4'd12,
        ALU_SLLW   = 4'd13,
        ALU_SRLW   = 4'd14,
        ALU_SRAW   = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; *W ops compute on the low 32 bits and sign-extend.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic [ALU_OP_WIDTH-1:0] op_i,
    output logic [DATA_WIDTH-1:0]   y_o
);

    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] sh;
    logic [4:0]     shw;
    logic [31:0]    w;

    always_comb begin
        sh  = b_i[SHW-1:0];
        shw = b_i[4:0];
        w   = '0;
        y_o = '0;
        case (alu_op_e'(op_i))
            ALU_ADD:    y_o = a_i + b_i;
            ALU_SUB:    y_o = a_i - b_i;
            ALU_OR:     y_o = a_i | b_i;
            ALU_AND:    y_o = a_i & b_i;
            ALU_XOR:    y_o = a_i ^ b_i;
            ALU_SLL:    y_o = a_i << sh;
            ALU_SRL:    y_o = a_i >> sh;
            ALU_SRA:    y_o = $unsigned($signed(a_i) >>> sh);
            ALU_SLT:    y_o = {{(DATA_WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:   y_o = {{(DATA_WIDTH-1){1'b0}}, a_i < b_i};
            ALU_COPY_B: y_o = b_i;
            ALU_ADDW:   w = a_i[31:0] + b_i[31:0];
            ALU_SUBW:   w = a_i[31:0] - b_i[31:0];
            ALU_SLLW:   w = a_i[31:0] << shw;
            ALU_SRLW:   w = a_i[31:0] >> shw;
            ALU_SRAW:   w = $unsigned($signed(a_i[31:0]) >>> shw);
            default:    y_o = '0;
        endcase
        if (op_i >= ALU_ADDW) begin
            y_o = {{(DATA_WIDTH-32){w[31]}}, w};
        end
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the first request at or after the pointer.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant_o = '0;
        gidx    = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr_q) + i) % N);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                gidx         = idx;
            end
        end
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = PW'((32'(gidx) + 32'd1) % N);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with a single registered result stage.
// Optional perf counters under macro ALU_SHARE_ARBITER_PERF_EN.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TAG_WIDTH  = 5,
    localparam int unsigned IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b_i,
    input  logic [NUM_REQ*ALU_OP_WIDTH-1:0] req_op_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]           rsp_data_o,
    output logic [IW-1:0]                   rsp_id_o,
    output logic [TAG_WIDTH-1:0]            rsp_tag_o
`ifdef ALU_SHARE_ARBITER_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]           perf_grant_cnt_o,
    output logic [31:0]                     perf_stall_cnt_o
`endif
);

    logic                    can_issue, transfer;
    logic [NUM_REQ-1:0]      grant;
    logic [IW-1:0]           gidx;
    logic [DATA_WIDTH-1:0]   alu_a, alu_b, alu_y;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [TAG_WIDTH-1:0]    gtag;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IW-1:0]         rsp_id_q, rsp_id_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (req_valid_i),
        .advance_i (transfer),
        .grant_o   (grant)
    );

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a_i  (alu_a),
        .b_i  (alu_b),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    // Ready is gated by reset so nothing is accepted while the flops are held.
    always_comb begin
        can_issue   = !rsp_valid_q || rsp_ready_i;
        req_ready_o = (rst_n_i && can_issue) ? grant : '0;
        transfer    = |(req_valid_i & req_ready_o);
        gidx        = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = '0;
        gtag        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                gidx   = IW'(k);
                alu_a  = req_a_i[k*DATA_WIDTH +: DATA_WIDTH];
                alu_b  = req_b_i[k*DATA_WIDTH +: DATA_WIDTH];
                alu_op = req_op_i[k*ALU_OP_WIDTH +: ALU_OP_WIDTH];
                gtag   = req_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_comb begin
        rsp_valid_d = transfer || (rsp_valid_q && !rsp_ready_i);
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        if (transfer) begin
            rsp_data_d = alu_y;
            rsp_id_d   = gidx;
            rsp_tag_d  = gtag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_tag_o   = rsp_tag_q;

`ifdef ALU_SHARE_ARBITER_PERF_EN
    logic [NUM_REQ*32-1:0] perf_grant_q, perf_grant_d;
    logic [31:0]           perf_stall_q, perf_stall_d;

    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (req_valid_i[k] && req_ready_o[k] && (perf_grant_q[k*32 +: 32] != '1)) begin
                perf_grant_d[k*32 +: 32] = perf_grant_q[k*32 +: 32] + 32'd1;
            end
        end
        if ((|req_valid_i) && !can_issue && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_cnt_o = perf_grant_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
